mem_arbiter: RTL
================

# mem_arbiter

Arbiter and sequencer that shares the single SPI memory engine between the core's instruction-fetch port and data port. It decodes the address map, grants one transaction at a time with data-priority plus anti-starvation, and drives the engine through a single-cycle issue and done handshake. It routes the read data back to the correct port and converts unmapped accesses and engine hangs into error responses.

## Interface
Parameters
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending; range 1–15.
- TIMEOUT_CYCLES, 1024: WAIT cycles without `be_done` before abort; must be ≥ 2, counter is 16 bits.

Ports
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `instr_req` in 1: fetch request, held until `instr_ready`.
- `instr_addr` in 32: fetch address.
- `instr_ready` out 1: one-cycle completion pulse.
- `instr_data` out 32: fetched word, held until the next fetch completion.
- `instr_err` out 1: pulses with `instr_ready` on error.
- `mem_re`, `mem_we` in 1 each: data read/write request, held until `mem_ready`.
- `mem_addr` in 32: data address.
- `mem_wdata` in 32: write data.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read word, updated only on a successful read completion.
- `mem_err` out 1: pulses with `mem_ready` on error.
- `be_req` out 1: one-cycle issue pulse to the engine.
- `be_flash` out 1: 1 = flash chip select, 0 = RAM.
- `be_we` out 1: write.
- `be_addr` out 24: device address.
- `be_wdata` out 32: write data.
- `be_done` in 1: engine completion pulse.
- `be_rdata` in 32: engine read data, valid with `be_done`.
- `be_abort` out 1: one-cycle pulse forcing the engine back to idle and deselecting both chips.

## Operation
- Decode
  - Fetch is legal only for `instr_addr[31:28]==4'h8`; maps to flash, `be_addr=instr_addr[23:0]`.
  - Data is legal only for `mem_addr[31:28]==4'h0`; maps to RAM, `be_addr=mem_addr[23:0]`.
  - Any other address is an error with no engine access.
  - `mem_we` and `mem_re` both high is treated as a write.
- State machine
  - IDLE: arbitrate. If no request, stay. If the winner is illegal, go to RESP with err=1. Otherwise latch `be_*` fields and the owner, then go to ISSUE.
  - ISSUE: `be_req=1` for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: on `be_done`, capture `be_rdata` and go to RESP (err=0). Otherwise increment the timeout counter. When the counter reaches TIMEOUT_CYCLES-1, pulse `be_abort` and go to RESP with err=1 (read data forced to 0, not written to `mem_rdata`/`instr_data`).
  - RESP: pulse the owner's ready (and err if set); update the owner's data register on a successful read; go to IDLE.
- Arbitration
  - Data wins over fetch unless `streak==STARVE_LIMIT`, in which case fetch wins.
  - `streak` (4 bits) increments on each data grant made while a fetch is pending; it clears on any fetch grant or when no fetch is pending.
- `be_done` outside WAIT is ignored. `be_done` and timeout in the same cycle: done wins, no abort.
- Requests are only sampled in IDLE. Changes to request signals during ISSUE, WAIT or RESP have no effect on the transaction in flight.

## Timing
- Reset (`rst_n` low at a clock edge)
  - State goes to IDLE and `streak` clears to 0.
  - All outputs go to 0, including `instr_data`/`mem_rdata` = 32'h0.
  - A transaction in flight is dropped with no ready pulse. `be_abort` is not pulsed; the engine shares the same reset.
- Legal access, request visible in IDLE at cycle 0:
  - `be_req` is high at cycle 1.
  - WAIT starts at cycle 2.
  - If `be_done` arrives at cycle d ≥ 2, ready is high at cycle d+1.
  - Minimum latency is 3 cycles.
- Illegal access: request at cycle 0, ready with err at cycle 1.
- Requesters sample ready at the clock edge ending RESP and must drop or replace their request by the following IDLE cycle.
- The arbiter returns to IDLE one cycle after RESP, so back-to-back grants are possible.
- All outputs are registered.

## Test plan
- Fetch 0x8000_0010, engine returns done 40 cycles after `be_req` with 0x0000_0013 -> `be_flash=1`, `be_addr=0x000010`, `instr_ready` pulse with `instr_data=0x0000_0013`, `instr_err=0`.
- Data write 0x0000_0100 with 0xDEADBEEF -> `be_flash=0`, `be_we=1`, `be_wdata=0xDEADBEEF`, `mem_ready` pulse, `mem_rdata` unchanged.
- Data read 0x4000_0000 -> `mem_ready`+`mem_err` at cycle 1, `be_req` never asserted.
- Fetch held high while data reads are issued back-to-back, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D...; `streak` returns to 0 after the fetch grant.
- TIMEOUT_CYCLES=8, engine never completes a read -> `be_abort` pulse, `mem_ready`+`mem_err`, `mem_rdata` keeps its old value. A second test with `be_done` arriving exactly on the timeout cycle -> normal completion, no abort.
- Assert `rst_n`=0 for one cycle mid-WAIT -> no ready pulse, all outputs 0, next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the SPI memory engine between fetch and data ports.
// Decodes addresses, arbitrates, sequences and times out transactions.
module mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ready,
  output logic [31:0] instr_data,
  output logic        instr_err,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        be_req,
  output logic        be_flash,
  output logic        be_we,
  output logic [23:0] be_addr,
  output logic [31:0] be_wdata,
  input  logic        be_done,
  input  logic [31:0] be_rdata,
  output logic        be_abort
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0]  SL_MAX   = 4'(STARVE_LIMIT);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  streak;
  logic [15:0] tmo;
  logic        own_d;

  logic mem_req;
  logic pick_i;
  logic pick_d;
  logic i_ok;
  logic d_ok;
  logic unused_addr;

  assign unused_addr = ^{instr_addr[27:24], mem_addr[27:24]};

  // Winner selection and address-map legality for the current requests.
  always_comb begin
    mem_req = mem_re | mem_we;
    pick_i  = instr_req && (!mem_req || streak == SL_MAX);
    pick_d  = mem_req && !pick_i;
    i_ok    = instr_addr[31:28] == 4'h8;
    d_ok    = mem_addr[31:28] == 4'h0;
  end

  // Transaction sequencer: IDLE -> ISSUE -> WAIT -> RESP, with all
  // handshake outputs registered so each pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      streak      <= 4'd0;
      tmo         <= 16'd0;
      own_d       <= 1'b0;
      instr_ready <= 1'b0;
      instr_data  <= 32'h0;
      instr_err   <= 1'b0;
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'h0;
      mem_err     <= 1'b0;
      be_req      <= 1'b0;
      be_flash    <= 1'b0;
      be_we       <= 1'b0;
      be_addr     <= 24'h0;
      be_wdata    <= 32'h0;
      be_abort    <= 1'b0;
    end else begin
      be_req      <= 1'b0;
      be_abort    <= 1'b0;
      instr_ready <= 1'b0;
      instr_err   <= 1'b0;
      mem_ready   <= 1'b0;
      mem_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_i) begin
            streak <= 4'd0;
            own_d  <= 1'b0;
            if (i_ok) begin
              be_flash <= 1'b1;
              be_we    <= 1'b0;
              be_addr  <= instr_addr[23:0];
              be_wdata <= 32'h0;
              be_req   <= 1'b1;
              state    <= S_ISSUE;
            end else begin
              instr_ready <= 1'b1;
              instr_err   <= 1'b1;
              state       <= S_RESP;
            end
          end else if (pick_d) begin
            streak <= instr_req ? streak + 4'd1 : 4'd0;
            own_d  <= 1'b1;
            if (d_ok) begin
              be_flash <= 1'b0;
              be_we    <= mem_we;
              be_addr  <= mem_addr[23:0];
              be_wdata <= mem_wdata;
              be_req   <= 1'b1;
              state    <= S_ISSUE;
            end else begin
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
              state     <= S_RESP;
            end
          end else begin
            streak <= 4'd0;
          end
        end
        S_ISSUE: begin
          tmo   <= 16'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (be_done) begin
            state <= S_RESP;
            if (own_d) begin
              mem_ready <= 1'b1;
              if (!be_we) mem_rdata <= be_rdata;
            end else begin
              instr_ready <= 1'b1;
              instr_data  <= be_rdata;
            end
          end else if (tmo == TMO_LAST) begin
            be_abort <= 1'b1;
            state    <= S_RESP;
            if (own_d) begin
              mem_ready <= 1'b1;
              mem_err   <= 1'b1;
            end else begin
              instr_ready <= 1'b1;
              instr_err   <= 1'b1;
            end
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
